// File: rtl/moller_pkt_pkg.sv
// Shared definitions for the packet checker: header field layout, FSM states and error-flag bit positions.
package moller_pkt_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned ID_LSB    = 56;
    localparam int unsigned ID_W      = 8;
    localparam int unsigned RSVD_LSB  = 48;
    localparam int unsigned RSVD_W    = 8;
    localparam int unsigned SEQ_LSB   = 16;
    localparam int unsigned SEQ_W     = 32;
    localparam int unsigned LEN_LSB   = 0;
    localparam int unsigned LEN_W     = 16;
    localparam int unsigned TS_LSB    = 0;
    localparam int unsigned TS_W      = 64;
    localparam int unsigned HDR_WORDS = 2;

    localparam int unsigned ERR_ID  = 0;
    localparam int unsigned ERR_SEQ = 1;
    localparam int unsigned ERR_LEN = 2;
    localparam int unsigned ERR_FRM = 3;
    localparam int unsigned ERR_TS  = 4;
    localparam int unsigned ERR_W   = 5;

    typedef enum logic [1:0] {
        ST_HDR0,
        ST_HDR1,
        ST_DATA
    } pkt_state_t;

    // A packet must hold both header words plus at least one sample.
    function automatic logic len_mismatch(input logic [LEN_W-1:0] cnt, input logic [LEN_W-1:0] len);
        return (cnt != len) || (len <= LEN_W'(HDR_WORDS));
    endfunction

endpackage

// File: rtl/axi_stream_skid.sv
// Two-entry skid buffer with a registered input ready; the tail entry can have bits OR-ed in while still held.
module axi_stream_skid #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             patch_en,
    input  logic [WIDTH-1:0] patch_mask
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_n;
    logic             push;
    logic             pop;
    logic             tail_kept;

    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    // The most recently written entry survives this edge unless it is the head being popped.
    assign tail_kept = (count == 2'd2) || ((count == 2'd1) && !pop);

    always_comb begin
        count_n = count + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            in_ready <= 1'b0;
        end else begin
            count    <= count_n;
            in_ready <= (count_n != 2'd2);
            if (patch_en && tail_kept) begin
                mem[~wr_ptr] <= mem[~wr_ptr] | patch_mask;
            end
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

endmodule

// File: rtl/axi_stream_pkt_checker.sv
// In-line checker for the framed packet stream: ID/sequence/length/framing checks, pass-through data, saturating counters.
// Timestamp monotonicity checking is built only when PKT_CHK_TS_CHECK_EN is defined.
module axi_stream_pkt_checker #(
    parameter logic [7:0]  EXPECTED_ID = 8'd0,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_cnt,
    input  logic [63:0]      in_tdata,
    input  logic             in_tfirst,
    input  logic             in_tlast,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [63:0]      out_tdata,
    output logic             out_tfirst,
    output logic             out_tlast,
    output logic [4:0]       out_terr,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_id_cnt,
    output logic [CNT_W-1:0] err_seq_cnt,
    output logic [CNT_W-1:0] err_len_cnt,
    output logic [CNT_W-1:0] err_frm_cnt,
    output logic [CNT_W-1:0] err_ts_cnt
);

    import moller_pkt_pkg::*;

    localparam int unsigned PAYLOAD_W = ERR_W + 2 + DATA_W;

    pkt_state_t       state;
    pkt_state_t       state_n;
    logic             beat;
    logic             hdr;
    logic             abort;
    logic [LEN_W-1:0] cur_len;
    logic [LEN_W-1:0] len_n;
    logic [LEN_W-1:0] word_cnt;
    logic [LEN_W-1:0] word_cnt_n;
    logic [SEQ_W-1:0] last_seq;
    logic [SEQ_W-1:0] seq_in;
    logic             seq_valid;
    logic [ERR_W-1:0] acc_err;
    logic [ERR_W-1:0] err_cur;
    logic [ERR_W-1:0] abort_err;
    logic [ERR_W-1:0] err_out;
    logic             ts_bad;
    logic [PAYLOAD_W-1:0] skid_out;
    logic [CNT_W-1:0] err_cnt [ERR_W];
    logic [CNT_W:0]   err_sum [ERR_W];
    logic [1:0]       err_inc [ERR_W];

    assign beat  = in_tvalid & in_tready;
    assign hdr   = in_tfirst | (state == ST_HDR0);
    assign abort = beat & in_tfirst & (state != ST_HDR0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HDR0;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (beat) begin
            if (hdr) begin
                state_n = in_tlast ? ST_HDR0 : ST_HDR1;
            end else begin
                state_n = in_tlast ? ST_HDR0 : ST_DATA;
            end
        end
    end

    always_comb begin
        seq_in = in_tdata[SEQ_LSB +: SEQ_W];
        len_n  = hdr ? in_tdata[LEN_LSB +: LEN_W] : cur_len;
        if (hdr) begin
            word_cnt_n = LEN_W'(1);
        end else if (state == ST_HDR1) begin
            word_cnt_n = LEN_W'(2);
        end else if (word_cnt == '1) begin
            word_cnt_n = word_cnt;
        end else begin
            word_cnt_n = word_cnt + LEN_W'(1);
        end
        err_cur = hdr ? '0 : acc_err;
        if (hdr) begin
            err_cur[ERR_ID]  = (in_tdata[ID_LSB +: ID_W] != EXPECTED_ID);
            err_cur[ERR_SEQ] = seq_valid && (seq_in != last_seq + SEQ_W'(1));
            err_cur[ERR_FRM] = !in_tfirst;
        end
        if (ts_bad) begin
            err_cur[ERR_TS] = 1'b1;
        end
        if (in_tlast) begin
            err_cur[ERR_LEN] = len_mismatch(word_cnt_n, len_n);
        end
        abort_err          = acc_err;
        abort_err[ERR_FRM] = 1'b1;
        abort_err[ERR_LEN] = len_mismatch(word_cnt, cur_len);
        err_out            = in_tlast ? err_cur : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_len   <= '0;
            word_cnt  <= '0;
            acc_err   <= '0;
            last_seq  <= '0;
            seq_valid <= 1'b0;
        end else begin
            if (beat) begin
                cur_len  <= len_n;
                word_cnt <= word_cnt_n;
                acc_err  <= err_cur;
            end
            if (beat && hdr) begin
                last_seq <= seq_in;
            end
            if (clr_cnt) begin
                seq_valid <= 1'b0;
            end else if (beat && hdr) begin
                seq_valid <= 1'b1;
            end
        end
    end

`ifdef PKT_CHK_TS_CHECK_EN
    logic [TS_W-1:0] last_ts;
    logic            ts_valid;

    assign ts_bad = (state == ST_HDR1) && !in_tfirst && ts_valid && (in_tdata[TS_LSB +: TS_W] <= last_ts);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_ts  <= '0;
            ts_valid <= 1'b0;
        end else begin
            if (beat && (state == ST_HDR1) && !in_tfirst) begin
                last_ts <= in_tdata[TS_LSB +: TS_W];
            end
            if (clr_cnt) begin
                ts_valid <= 1'b0;
            end else if (beat && (state == ST_HDR1) && !in_tfirst) begin
                ts_valid <= 1'b1;
            end
        end
    end
`else
    assign ts_bad = 1'b0;
`endif

    // An aborting tfirst beat may also complete a 1-word packet, so a counter can step by two.
    always_comb begin
        for (int unsigned b = 0; b < ERR_W; b++) begin
            err_inc[b] = {1'b0, beat & in_tlast & err_cur[b]} + {1'b0, abort & abort_err[b]};
            err_sum[b] = {1'b0, err_cnt[b]} + (CNT_W + 1)'(err_inc[b]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
            for (int unsigned b = 0; b < ERR_W; b++) begin
                err_cnt[b] <= '0;
            end
        end else if (clr_cnt) begin
            pkt_cnt <= '0;
            for (int unsigned b = 0; b < ERR_W; b++) begin
                err_cnt[b] <= '0;
            end
        end else begin
            if (beat && in_tlast && (pkt_cnt != '1)) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
            for (int unsigned b = 0; b < ERR_W; b++) begin
                err_cnt[b] <= err_sum[b][CNT_W] ? '1 : err_sum[b][CNT_W-1:0];
            end
        end
    end

    assign err_id_cnt  = err_cnt[ERR_ID];
    assign err_seq_cnt = err_cnt[ERR_SEQ];
    assign err_len_cnt = err_cnt[ERR_LEN];
    assign err_frm_cnt = err_cnt[ERR_FRM];
    assign err_ts_cnt  = err_cnt[ERR_TS];

    axi_stream_skid #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    ({err_out, in_tlast, in_tfirst, in_tdata}),
        .in_valid   (in_tvalid),
        .in_ready   (in_tready),
        .out_data   (skid_out),
        .out_valid  (out_tvalid),
        .out_ready  (out_tready),
        .patch_en   (abort),
        .patch_mask ({abort_err, {(PAYLOAD_W - ERR_W){1'b0}}})
    );

    assign {out_terr, out_tlast, out_tfirst, out_tdata} = skid_out;

endmodule

// File: tb/tb_axi_stream_pkt_checker.sv
// Self-checking bench for axi_stream_pkt_checker: packet table, random backpressure, abort, reset and clear sequences.
module tb_axi_stream_pkt_checker;

    localparam int unsigned CNT_W = 32;
`ifdef PKT_CHK_TS_CHECK_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr_cnt = 1'b0;
    logic [63:0]      in_tdata = '0;
    logic             in_tfirst = 1'b0;
    logic             in_tlast = 1'b0;
    logic             in_tvalid = 1'b0;
    logic             in_tready;
    logic [63:0]      out_tdata;
    logic             out_tfirst;
    logic             out_tlast;
    logic [4:0]       out_terr;
    logic             out_tvalid;
    logic             out_tready = 1'b1;
    logic [CNT_W-1:0] pkt_cnt, err_id_cnt, err_seq_cnt, err_len_cnt, err_frm_cnt, err_ts_cnt;

    typedef struct {
        logic [63:0] data;
        logic        first;
        logic        last;
        logic [4:0]  terr;
    } beat_t;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] seq;
        logic [15:0] len;
        int unsigned n;
        bit          nofirst;
        logic [4:0]  terr;
    } pkt_vec_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    bit          rand_rdy = 1'b0;
    bit          hold_rdy = 1'b0;
    bit          burst = 1'b0;
    logic [63:0] ts_ctr = 64'd1000;

    axi_stream_pkt_checker #(
        .EXPECTED_ID(8'd0),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_cnt    (clr_cnt),
        .in_tdata   (in_tdata),
        .in_tfirst  (in_tfirst),
        .in_tlast   (in_tlast),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tfirst (out_tfirst),
        .out_tlast  (out_tlast),
        .out_terr   (out_terr),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .pkt_cnt    (pkt_cnt),
        .err_id_cnt (err_id_cnt),
        .err_seq_cnt(err_seq_cnt),
        .err_len_cnt(err_len_cnt),
        .err_frm_cnt(err_frm_cnt),
        .err_ts_cnt (err_ts_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_tready = hold_rdy ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_beat: got data %0h expected no output beat", out_tdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat", {out_terr, out_tlast, out_tfirst, out_tdata},
                      {mon_e.terr, mon_e.last, mon_e.first, mon_e.data});
            end
        end
    end

    task automatic send_word(input logic [63:0] d, input logic f, input logic l,
                             input logic [4:0] et, input bit clr);
        beat_t       b;
        int unsigned waited = 0;
        in_tdata  = d;
        in_tfirst = f;
        in_tlast  = l;
        in_tvalid = 1'b1;
        clr_cnt   = clr;
        @(negedge clk);
        while (!in_tready) begin
            waited++;
            if (waited > 2000) begin
                total++;
                $display("FAIL ready_timeout: in_tready got 0 expected 1");
                $display("%0d/%0d checks passed", passed, total);
                $fatal(1);
            end
            @(negedge clk);
        end
        b.data  = d;
        b.first = f;
        b.last  = l;
        b.terr  = et;
        exp_q.push_back(b);
        @(posedge clk);
        #1;
        in_tvalid = 1'b0;
        in_tfirst = 1'b0;
        in_tlast  = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic send_pkt(input pkt_vec_t p, input logic [63:0] ts, input bit clr_last);
        for (int unsigned w = 0; w < p.n; w++) begin
            logic [63:0] d;
            if (burst && ($urandom_range(0, 3) == 3)) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            if (w == 0) d = {p.id, 8'h00, p.seq, p.len};
            else if (w == 1) d = ts;
            else d = {$urandom, $urandom};
            send_word(d, (w == 0) && !p.nofirst, w == p.n - 1,
                      (w == p.n - 1) ? p.terr : 5'h00, clr_last && (w == p.n - 1));
        end
    endtask

    task automatic wait_drain();
        int unsigned n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || out_tvalid) && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || out_tvalid) begin
            total++;
            $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input int p, input int id, input int sq,
                              input int ln, input int fr, input int ts);
        check({tag, "_pkt_cnt"}, pkt_cnt, p);
        check({tag, "_id_cnt"}, err_id_cnt, id);
        check({tag, "_seq_cnt"}, err_seq_cnt, sq);
        check({tag, "_len_cnt"}, err_len_cnt, ln);
        check({tag, "_frm_cnt"}, err_frm_cnt, fr);
        check({tag, "_ts_cnt"}, err_ts_cnt, ts);
    endtask

    initial begin
        pkt_vec_t    vecs[15];
        pkt_vec_t    p;
        beat_t       e;
        int          e_pkt = 0, e_id = 0, e_seq = 0, e_len = 0, e_frm = 0;
        int          start;
        logic [31:0] seq;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_tready", in_tready, 0);
        check("rst_out_tvalid", out_tvalid, 0);
        check("rst_out_tdata", out_tdata, 0);
        check("rst_out_terr", {out_terr, out_tlast, out_tfirst}, 0);
        check_cnts("rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", in_tready, 1);

        // Packet table: id, seq, len, words sent, missing tfirst, expected flags on tlast
        vecs[0]  = '{8'h00, 32'd5,          16'd6, 6, 1'b0, 5'h00};
        vecs[1]  = '{8'h00, 32'd7,          16'd4, 4, 1'b0, 5'h02};
        vecs[2]  = '{8'h00, 32'd9,          16'd4, 4, 1'b0, 5'h02};
        vecs[3]  = '{8'h00, 32'hFFFF_FFFF,  16'd3, 3, 1'b0, 5'h02};
        vecs[4]  = '{8'h00, 32'd0,          16'd3, 3, 1'b0, 5'h00};
        vecs[5]  = '{8'h00, 32'd1,          16'd6, 4, 1'b0, 5'h04};
        vecs[6]  = '{8'h00, 32'd2,          16'd4, 5, 1'b0, 5'h04};
        vecs[7]  = '{8'h00, 32'd3,          16'd6, 1, 1'b0, 5'h04};
        vecs[8]  = '{8'h00, 32'd4,          16'd3, 3, 1'b0, 5'h00};
        vecs[9]  = '{8'h5A, 32'd5,          16'd3, 3, 1'b0, 5'h01};
        vecs[10] = '{8'h33, 32'd7,          16'd5, 2, 1'b0, 5'h07};
        vecs[11] = '{8'h00, 32'd8,          16'd2, 2, 1'b0, 5'h04};
        vecs[12] = '{8'h00, 32'd9,          16'd3, 3, 1'b0, 5'h00};
        vecs[13] = '{8'h00, 32'd10,         16'd3, 3, 1'b1, 5'h08};
        vecs[14] = '{8'h00, 32'd12,         16'd4, 4, 1'b1, 5'h0A};
        for (int i = 0; i < 15; i++) begin
            ts_ctr += 64'd1;
            send_pkt(vecs[i], ts_ctr, 1'b0);
            e_pkt++;
            e_id  += int'(vecs[i].terr[0]);
            e_seq += int'(vecs[i].terr[1]);
            e_len += int'(vecs[i].terr[2]);
            e_frm += int'(vecs[i].terr[3]);
        end
        wait_drain();
        check_cnts("table", e_pkt, e_id, e_seq, e_len, e_frm, 0);

        // Random backpressure with bursty input
        pulse_clr();
        rand_rdy = 1'b1;
        burst    = 1'b1;
        seq      = 32'd1000;
        for (int i = 0; i < 1000; i++) begin
            int unsigned n = $urandom_range(3, 8);
            p = '{8'h00, seq, 16'(n), n, 1'b0, 5'h00};
            ts_ctr += 64'd1;
            send_pkt(p, ts_ctr, 1'b0);
            seq++;
        end
        rand_rdy = 1'b0;
        burst    = 1'b0;
        wait_drain();
        check_cnts("random", 1000, 0, 0, 0, 0, 0);

        // Full throughput with out_tready high
        start = cyc;
        p = '{8'h00, seq, 16'd40, 40, 1'b0, 5'h00};
        ts_ctr += 64'd1;
        send_pkt(p, ts_ctr, 1'b0);
        check("throughput_cycles", cyc - start, 40);
        wait_drain();

        // tfirst on word 3 aborts the packet; the new packet is checked from that word
        pulse_clr();
        ts_ctr += 64'd1;
        send_word({8'h00, 8'h00, 32'd20, 16'd6}, 1'b1, 1'b0, 5'h00, 1'b0);
        send_word(ts_ctr, 1'b0, 1'b0, 5'h00, 1'b0);
        send_word({$urandom, $urandom}, 1'b0, 1'b0, 5'h00, 1'b0);
        ts_ctr += 64'd1;
        send_word({8'h00, 8'h00, 32'd21, 16'd4}, 1'b1, 1'b0, 5'h00, 1'b0);
        send_word(ts_ctr, 1'b0, 1'b0, 5'h00, 1'b0);
        send_word({$urandom, $urandom}, 1'b0, 1'b0, 5'h00, 1'b0);
        send_word({$urandom, $urandom}, 1'b0, 1'b1, 5'h00, 1'b0);
        p = '{8'h00, 32'd23, 16'd3, 3, 1'b0, 5'h02};
        ts_ctr += 64'd1;
        send_pkt(p, ts_ctr, 1'b0);
        wait_drain();
        check_cnts("abort", 2, 0, 1, 1, 1, 0);

        // Abort while the preceding beat is still held: its flags are patched in
        @(negedge clk);
        hold_rdy = 1'b1;
        @(posedge clk);
        #2;
        send_word({8'h00, 8'h00, 32'd24, 16'd6}, 1'b1, 1'b0, 5'h00, 1'b0);
        e = exp_q.pop_back();
        e.terr = 5'h0C;
        exp_q.push_back(e);
        send_word({8'h00, 8'h00, 32'd25, 16'd3}, 1'b1, 1'b0, 5'h00, 1'b0);
        hold_rdy = 1'b0;
        ts_ctr += 64'd1;
        send_word(ts_ctr, 1'b0, 1'b0, 5'h00, 1'b0);
        send_word({$urandom, $urandom}, 1'b0, 1'b1, 5'h00, 1'b0);
        wait_drain();
        check_cnts("held_abort", 3, 0, 1, 2, 2, 0);

        // Async reset mid-packet
        send_word({8'h00, 8'h00, 32'd50, 16'd6}, 1'b1, 1'b0, 5'h00, 1'b0);
        send_word(ts_ctr + 64'd1, 1'b0, 1'b0, 5'h00, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_in_tready", in_tready, 0);
        check("midrst_out_tvalid", out_tvalid, 0);
        check("midrst_pkt_cnt", pkt_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        p = '{8'h00, 32'd77, 16'd3, 3, 1'b0, 5'h00};
        ts_ctr += 64'd1;
        send_pkt(p, ts_ctr, 1'b0);
        p = '{8'h11, 32'd78, 16'd3, 3, 1'b0, 5'h01};
        ts_ctr += 64'd1;
        send_pkt(p, ts_ctr, 1'b1);
        wait_drain();
        check_cnts("clr_wins", 0, 0, 0, 0, 0, 0);
        p = '{8'h00, 32'd200, 16'd3, 3, 1'b0, 5'h00};
        ts_ctr += 64'd1;
        send_pkt(p, ts_ctr, 1'b0);
        wait_drain();
        check("resync_pkt_cnt", pkt_cnt, 1);
        check("resync_seq_cnt", err_seq_cnt, 0);

        // Repeated timestamp
        pulse_clr();
        p = '{8'h00, 32'd300, 16'd3, 3, 1'b0, 5'h00};
        send_pkt(p, 64'd100, 1'b0);
        p = '{8'h00, 32'd301, 16'd3, 3, 1'b0, TS_EN ? 5'h10 : 5'h00};
        send_pkt(p, 64'd100, 1'b0);
        wait_drain();
        check("ts_cnt", err_ts_cnt, TS_EN ? 1 : 0);
        check("ts_pkt_cnt", pkt_cnt, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
